// File: rtl/bundled_rx_sync.sv
// Receiver for a 4-phase bundled-data channel: synchronises the delayed request,
// captures the bundle into a one-entry holding register and returns the acknowledge.
module bundled_rx_sync #(
    parameter int size        = 8,
    parameter int sync_stages = 2,
    parameter int cnt_width   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_in,
    input  logic [size-1:0]      data_in,
    output logic                 ack_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [size-1:0]      out_data,
    output logic [cnt_width-1:0] xfer_count,
    output logic                 proto_err
);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [sync_stages-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic                   valid_q, valid_d;
    logic [size-1:0]        data_q, data_d;
    logic [cnt_width-1:0]   cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   req_prev_q, req_prev_d;

    logic req_s;
    logic slot_free;
    logic capture;

    assign req_s     = sync_q[sync_stages-1];
    assign slot_free = !valid_q || out_ready;
    assign capture   = (state_q == S_IDLE) && req_s && slot_free;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d    = state_q;
        ack_d      = ack_q;
        valid_d    = valid_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        sync_d     = {sync_q[sync_stages-2:0], req_in};
        req_prev_d = req_s;

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + cnt_width'(1);
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Consumption only empties the slot when it is not being refilled on the same edge.
        if (valid_q && out_ready && !capture) begin
            valid_d = 1'b0;
        end

        // A request seen pending in idle that vanishes before any ack is a sender violation.
        if ((state_q == S_IDLE) && req_prev_q && !req_s) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            req_prev_q <= req_prev_d;
        end
    end

    assign ack_out    = ack_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign xfer_count = cnt_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_bundled_rx_sync.sv
// Self-checking bench for bundled_rx_sync: vector table, directed corner cases and a
// randomized 256-word stream, all compared against a queue-based reference model.
module tb_bundled_rx_sync;

    localparam int SIZE = 8;
    localparam int SS   = 2;
    localparam int CW   = 16;
    localparam int CWN  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_in = 1'b0;
    logic [SIZE-1:0] data_in = '0;
    logic            out_ready = 1'b0;

    logic            ack_out, out_valid, proto_err;
    logic [SIZE-1:0] out_data;
    logic [CW-1:0]   xfer_count;

    logic            ack_n, valid_n, err_n;
    logic [SIZE-1:0] data_n;
    logic [CWN-1:0]  count_n;

    bundled_rx_sync #(.size(SIZE), .sync_stages(SS), .cnt_width(CW)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .xfer_count(xfer_count), .proto_err(proto_err)
    );

    // Narrow-counter instance, driven identically, used for the wrap behaviour.
    bundled_rx_sync #(.size(SIZE), .sync_stages(SS), .cnt_width(CWN)) dut_n (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_n), .out_valid(valid_n), .out_ready(out_ready),
        .out_data(data_n), .xfer_count(count_n), .proto_err(err_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the request line is a queue of past req_in samples.
    bit            m_ack, m_valid, m_err, m_prev;
    logic [7:0]    m_data;
    logic [CW-1:0] m_cnt;
    bit            m_line[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rs, was_ack, slot_free;
        if (rst) begin
            m_ack = 0; m_valid = 0; m_err = 0; m_prev = 0;
            m_data = '0; m_cnt = '0;
            m_line = {};
            repeat (SS) m_line.push_back(1'b0);
        end else begin
            rs        = m_line[0];
            was_ack   = m_ack;
            slot_free = !m_valid || out_ready;
            if (!was_ack && rs && slot_free) begin
                m_data  = data_in;
                m_valid = 1;
                m_ack   = 1;
                m_cnt   = m_cnt + 1;
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (was_ack && !rs) m_ack = 0;
            end
            if (!was_ack && m_prev && !rs) m_err = 1;
            m_prev = rs;
            void'(m_line.pop_front());
            m_line.push_back(req_in);
        end
    endtask

    task automatic compare_all();
        check("model.ack",    ack_out,    m_ack);
        check("model.valid",  out_valid,  m_valid);
        check("model.data",   out_data,   m_data);
        check("model.count",  xfer_count, m_cnt);
        check("model.err",    proto_err,  m_err);
        check("model.count4", count_n,    m_cnt[CWN-1:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_ack(input bit lvl, input int budget, input string nm);
        int n = 0;
        while (ack_out !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(nm, ack_out, lvl);
    endtask

    task automatic xfer(input logic [7:0] d);
        data_in = d;
        req_in  = 1'b1;
        wait_ack(1'b1, 50, "xfer.ack_rise");
        req_in = 1'b0;
        wait_ack(1'b0, 50, "xfer.ack_fall");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         req;
        logic [7:0] din;
        bit         rdy;
        bit         e_ack;
        bit         e_valid;
        logic [7:0] e_data;
        logic [15:0] e_cnt;
        bit         e_err;
    } vec_t;

    vec_t vt[8];

    initial begin
        // Single transfer of 8'hA5 from reset, one row per clock edge.
        vt[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 16'd1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 16'd1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 16'd1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd1, 1'b0};
        vt[7] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst       = vt[i].rst;
            req_in    = vt[i].req;
            data_in   = vt[i].din;
            out_ready = vt[i].rdy;
            tick();
            check($sformatf("vec%0d.ack", i),   ack_out,    vt[i].e_ack);
            check($sformatf("vec%0d.valid", i), out_valid,  vt[i].e_valid);
            check($sformatf("vec%0d.data", i),  out_data,   vt[i].e_data);
            check($sformatf("vec%0d.count", i), xfer_count, vt[i].e_cnt);
            check($sformatf("vec%0d.err", i),   proto_err,  vt[i].e_err);
        end

        // Backpressure: second request held off while 8'h11 is unconsumed.
        do_reset();
        out_ready = 1'b0;
        xfer(8'h11);
        data_in = 8'h22;
        req_in  = 1'b1;
        repeat (8) tick();
        check("bp.no_ack", ack_out, 1'b0);
        check("bp.valid",  out_valid, 1'b1);
        check("bp.held",   out_data, 8'h11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.capture", out_data, 8'h22);
        check("bp.valid2",  out_valid, 1'b1);
        check("bp.ack",     ack_out, 1'b1);
        check("bp.count",   xfer_count, 16'd2);
        req_in = 1'b0;
        wait_ack(1'b0, 50, "bp.ack_fall");

        // Protocol violation: request withdrawn while the slot is full.
        req_in = 1'b1;
        repeat (5) tick();
        req_in = 1'b0;
        repeat (6) tick();
        check("proto.set",   proto_err, 1'b1);
        check("proto.noack", ack_out, 1'b0);
        out_ready = 1'b1;
        xfer(8'h33);
        xfer(8'h44);
        check("proto.sticky", proto_err, 1'b1);
        check("proto.data",   out_data, 8'h44);
        do_reset();
        check("proto.cleared", proto_err, 1'b0);

        // Reset while in the acknowledge phase with a word held.
        out_ready = 1'b0;
        data_in   = 8'h5A;
        req_in    = 1'b1;
        wait_ack(1'b1, 50, "rst.ack_rise");
        check("rst.pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst.ack",   ack_out, 1'b0);
        check("rst.valid", out_valid, 1'b0);
        check("rst.count", xfer_count, 16'd0);
        check("rst.data",  out_data, 8'h00);
        for (int i = 0; i < SS; i++) begin
            tick();
            check($sformatf("rst.wait%0d", i), ack_out, 1'b0);
        end
        tick();
        check("rst.recap_ack",   ack_out, 1'b1);
        check("rst.recap_valid", out_valid, 1'b1);
        check("rst.recap_data",  out_data, 8'h5A);
        check("rst.recap_count", xfer_count, 16'd1);
        req_in = 1'b0;
        wait_ack(1'b0, 50, "rst.ack_fall");

        // Counter wrap on the 4-bit instance.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) xfer(8'(i));
        check("wrap.count4",  count_n, 4'd1);
        check("wrap.count16", xfer_count, 16'd17);

        // Randomized stream of 256 words with random downstream readiness.
        do_reset();
        begin
            int sent  = 0;
            int rcvd  = 0;
            int cyc   = 0;
            int phase = 0;
            while (rcvd < 256 && cyc < 20000) begin
                case (phase)
                    0: if (sent < 256) begin
                        data_in = 8'(sent);
                        req_in  = 1'b1;
                        phase   = 1;
                    end
                    1: if (ack_out) begin
                        req_in = 1'b0;
                        sent++;
                        phase = 2;
                    end
                    default: if (!ack_out) phase = 0;
                endcase
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check("stream.order", out_data, rcvd[7:0]);
                    rcvd++;
                end
                tick();
                cyc++;
            end
            check("stream.received", rcvd, 256);
            check("stream.count",    xfer_count, 16'd256);
            check("stream.err",      proto_err, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
